// File: rtl/alu_issue.sv
// Command FIFO and single-issue sequencer in front of a registered ALU.
// Buffers {op, a, b} commands, issues one at a time, and returns each result over valid/ready.
module alu_issue #(
  parameter int W       = 4,
  parameter int OPW     = 3,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  input  logic [OPW-1:0]           in_op,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [OPW-1:0]           alu_op,
  input  logic [W-1:0]             alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_result,
  output logic [OPW-1:0]           out_op,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   rdPtr_q, wrPtr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [LW-1:0]   waitCnt_q;
  logic [W-1:0]    aluA_q, aluB_q, outResult_q;
  logic [OPW-1:0]  aluOp_q, outOp_q;
  logic            outValid_q, err_q;

  logic [W-1:0]    memA [DEPTH];
  logic [W-1:0]    memB [DEPTH];
  logic [OPW-1:0]  memOp [DEPTH];

  logic accept, legal, push, pop, capture, retire;

  // Opcodes above "not" are unimplemented; ready does not depend on legality.
  assign legal    = (in_op < OPW'(5));
  assign in_ready = (count_q < CW'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign push     = accept & legal;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (waitCnt_q == '0) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          retire = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      memA[wrPtr_q]  <= in_a;
      memB[wrPtr_q]  <= in_b;
      memOp[wrPtr_q] <= in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      waitCnt_q   <= '0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluOp_q     <= '0;
      outValid_q  <= 1'b0;
      outResult_q <= '0;
      outOp_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= accept & ~legal;
      if (push) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q   <= rdPtr_q + AW'(1);
        aluA_q    <= memA[rdPtr_q];
        aluB_q    <= memB[rdPtr_q];
        aluOp_q   <= memOp[rdPtr_q];
        waitCnt_q <= LW'(ALU_LAT);
      end else if (state_q == EXEC && waitCnt_q != '0) begin
        waitCnt_q <= waitCnt_q - LW'(1);
      end
      // The ALU output is captured once its pipeline has drained the issued operands.
      if (capture) begin
        outResult_q <= alu_result;
        outOp_q     <= aluOp_q;
        outValid_q  <= 1'b1;
      end else if (retire) begin
        outValid_q  <= 1'b0;
      end
    end
  end

  assign alu_a      = aluA_q;
  assign alu_b      = aluB_q;
  assign alu_op     = aluOp_q;
  assign out_valid  = outValid_q;
  assign out_result = outResult_q;
  assign out_op     = outOp_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural ALU and a result scoreboard.
// Directed scenarios followed by a randomized phase, all checked against an in-order expected queue.
module tb_alu_issue;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] aluRes;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [2:0] out_op;
  logic       err;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [6:0] expQ[$];
  logic [3:0] gotQ[$];
  int         hsTimes[$];

  alu_issue #(.W(4), .OPW(3), .DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(aluRes),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op),
    .err(err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain-arithmetic definition of what the ALU computes for each legal opcode.
  function automatic logic [3:0] refAlu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0:    r = (ia + ib) % 16;
      3'd1:    r = (ia - ib + 16) % 16;
      3'd2:    r = ia & ib;
      3'd3:    r = ia | ib;
      default: r = 15 - ia;
    endcase
    return 4'(r);
  endfunction

  // Single-stage registered ALU sitting downstream of the issue outputs.
  always_ff @(posedge clk) begin
    if (rst) aluRes <= 4'd0;
    else     aluRes <= refAlu(alu_op, alu_a, alu_b);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [3:0] a,
                               input logic [3:0] b, input logic rdy);
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
  endtask

  // One clock: score the handshakes seen at this edge, then check invariants after it.
  task automatic stepCycle();
    logic       acc, hs, legal, pv, pr;
    logic [3:0] pres;
    logic [2:0] pop;
    logic [6:0] e;
    int         outstanding;
    acc   = in_valid & in_ready;
    hs    = out_valid & out_ready;
    legal = (in_op <= 3'd4);
    pv    = out_valid;
    pr    = out_ready;
    pres  = out_result;
    pop   = out_op;
    if (hs) begin
      checkOutput("result_expected", expQ.size() > 0, 1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("result", out_result, e[3:0]);
        checkOutput("result_op", out_op, e[6:4]);
        gotQ.push_back(out_result);
        hsTimes.push_back(cyc);
      end
    end
    if (acc && legal) expQ.push_back({in_op, refAlu(in_op, in_a, in_b)});
    @(posedge clk);
    #1;
    cyc++;
    checkOutput("err", err, acc && !legal);
    if (pv && !pr) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_result", out_result, pres);
      checkOutput("hold_op", out_op, pop);
    end
    if (out_valid) checkOutput("no_stale", expQ.size() > 0, 1);
    outstanding = expQ.size();
    checkOutput("count_track", (int'(count) == outstanding) || (int'(count) + 1 == outstanding), 1);
    checkOutput("in_ready", in_ready, count < 3'd4);
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    expQ.delete();
    checkOutput("rst_count", count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_result", out_result, 0);
    checkOutput("rst_out_op", out_op, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_alu_op", alu_op, 0);
  endtask

  task automatic drain();
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 80 && (expQ.size() > 0 || out_valid); i++) stepCycle();
    checkOutput("drain_empty", expQ.size(), 0);
    checkOutput("drain_valid", out_valid, 0);
  endtask

  // Directed scenarios first, then a randomized run against the scoreboard.
  initial begin
    logic [2:0] ops[5];
    logic [3:0] as[5];
    logic [3:0] bs[5];
    logic [3:0] want[5];
    int         accepted;
    int         waited;

    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    applyReset();

    $display("[TB] single add");
    applyStimulus(1'b1, 3'd0, 4'd3, 4'd5, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      stepCycle();
      checkOutput("latency_valid", out_valid, (k == 3));
    end
    checkOutput("add_result", out_result, 4'd8);
    checkOutput("add_op", out_op, 3'd0);
    stepCycle();
    checkOutput("single_cycle_valid", out_valid, 0);

    $display("[TB] back-to-back");
    ops  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    as   = '{4'd15, 4'd1, 4'b1100, 4'b1100, 4'b0101};
    bs   = '{4'd1, 4'd2, 4'b1010, 4'b1010, 4'd0};
    want = '{4'd0, 4'd15, 4'b1000, 4'b1110, 4'b1010};
    gotQ.delete();
    hsTimes.delete();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, ops[i], as[i], bs[i], 1'b1);
      stepCycle();
    end
    drain();
    checkOutput("b2b_count", gotQ.size(), 5);
    for (int i = 0; i < 5 && i < gotQ.size(); i++) checkOutput("b2b_value", gotQ[i], want[i]);
    for (int i = 1; i < hsTimes.size(); i++) checkOutput("b2b_spacing", hsTimes[i] - hsTimes[i-1], 3);

    $display("[TB] illegal opcode");
    applyStimulus(1'b1, 3'd5, 4'd1, 4'd1, 1'b1);
    stepCycle();
    checkOutput("illegal_err", err, 1);
    checkOutput("illegal_count", count, 0);
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
    stepCycle();
    checkOutput("illegal_err_clear", err, 0);
    repeat (3) begin
      stepCycle();
      checkOutput("illegal_no_valid", out_valid, 0);
    end
    applyStimulus(1'b1, 3'd1, 4'd9, 4'd4, 1'b1);
    stepCycle();
    gotQ.delete();
    drain();
    checkOutput("after_illegal_count", gotQ.size(), 1);
    if (gotQ.size() > 0) checkOutput("after_illegal_value", gotQ[0], 4'd5);

    $display("[TB] backpressure");
    accepted = 0;
    gotQ.delete();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 3'(i % 5), 4'(i + 2), 4'(i), 1'b0);
      if (in_ready) accepted++;
      stepCycle();
    end
    checkOutput("bp_accepted", accepted, 5);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_count", count, 4);
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
    repeat (2) stepCycle();
    checkOutput("bp_still_full", in_ready, 0);
    drain();
    checkOutput("bp_results", gotQ.size(), 5);
    checkOutput("bp_ready_back", in_ready, 1);

    $display("[TB] reset during EXEC");
    applyStimulus(1'b1, 3'd0, 4'd1, 4'd1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 3'd1, 4'd7, 4'd2, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 3'd2, 4'd15, 4'd3, 1'b1);
    stepCycle();
    checkOutput("pre_rst_count", count, 2);
    applyReset();
    repeat (8) begin
      stepCycle();
      checkOutput("post_rst_no_valid", out_valid, 0);
    end

    $display("[TB] HOLD stall and reissue");
    applyStimulus(1'b1, 3'd0, 4'd2, 4'd2, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 3'd3, 4'd4, 4'd1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
    waited = 0;
    while (!out_valid && waited < 10) begin
      stepCycle();
      waited++;
    end
    checkOutput("stall_valid", out_valid, 1);
    repeat (3) stepCycle();
    checkOutput("stall_result", out_result, 4'd4);
    checkOutput("stall_op", out_op, 3'd0);
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
    stepCycle();
    checkOutput("reissue_a", alu_a, 4'd4);
    checkOutput("reissue_b", alu_b, 4'd1);
    checkOutput("reissue_op", alu_op, 3'd3);
    checkOutput("reissue_valid_low", out_valid, 0);
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0));
      stepCycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Command buffer and issue stage sitting directly upstream of the registered 4-bit `alu`. It accepts `{op, a, b}` commands over a valid/ready handshake and buffers them in a small FIFO. It drives them one at a time onto the ALU's `a`/`b`/`op` inputs, captures the ALU's registered `result` after a fixed latency, and presents it downstream over a second valid/ready handshake. Opcodes the ALU does not implement are rejected at the input.

## Interface
- `W`, 4: operand and result width; matches the ALU.
- `OPW`, 3: opcode width; matches the ALU.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ALU_LAT`, 1: ALU register stages between input sample and `result` valid.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high. Shared with the ALU instance.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  command accepted when `in_valid & in_ready` at an edge.
- `in_a`  in  W  operand a.
- `in_b`  in  W  operand b.
- `in_op`  in  OPW  opcode.
- `alu_a`  out  W  registered; to ALU `a`.
- `alu_b`  out  W  registered; to ALU `b`.
- `alu_op`  out  OPW  registered; to ALU `op`.
- `alu_result`  in  W  from ALU `result`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  downstream accepts.
- `out_result`  out  W  captured ALU result.
- `out_op`  out  OPW  opcode that produced `out_result`.
- `err`  out  1  one-cycle pulse on rejected opcode.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Legal opcodes: 000 add, 001 sub, 010 and, 011 or, 100 not. Opcodes 101–111 are illegal.
- Input handshake:
  - `in_ready = (count < DEPTH)`; it does not depend on a same-cycle pop.
  - An accepted legal command is written at the FIFO tail.
  - An accepted illegal command is discarded: no FIFO write, `err`=1 for the following cycle.
  - `in_ready` is evaluated identically for legal and illegal opcodes.
- FIFO: circular buffer with a read pointer, a write pointer and `count`. Push and pop on the same edge leave `count` unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if `count`>0, load the FIFO head into `alu_a`/`alu_b`/`alu_op`, pop, load `wait_cnt`=ALU_LAT, go to EXEC.
  - EXEC: decrement `wait_cnt` each cycle. At 0, capture `alu_result` into `out_result`, copy `alu_op` to `out_op`, set `out_valid`, go to HOLD.
  - HOLD: hold `out_*` stable until `out_valid & out_ready`. On that edge, clear `out_valid`. If `count`>0 on that edge, issue the next head and go to EXEC; otherwise go to IDLE.
- At most one command is in flight or held at any time; `alu_*` are never changed while in EXEC.
- `alu_*` keep their last issued values in IDLE and HOLD.
- Arithmetic is performed by the ALU; this block does no width extension. Results wrap modulo 2^W.
- Reset, including mid-operation:
  - pointers, `count`, FSM→IDLE, `wait_cnt`=0;
  - `alu_a`/`alu_b`/`alu_op`=0;
  - `out_valid`=0, `out_result`=0, `out_op`=0, `err`=0.
  - The in-flight command and all FIFO contents are dropped.
  - `in_ready`=1 in the first cycle after reset deasserts.

## Timing
- All outputs are registered except `in_ready`, which is combinational from `count`.
- Accept edge A into an empty FIFO:
  - issue at A+1;
  - ALU samples at A+2;
  - capture at A+2+ALU_LAT.
  - With ALU_LAT=1, `out_valid` is high 3 cycles after A.
- Back-to-back throughput with `out_ready`=1: one result per ALU_LAT+2 cycles.
- `err` is high for exactly the cycle after the rejecting edge.
- Maximum commands accepted while `out_ready`=0 from empty: DEPTH+1 (one in flight or held, DEPTH buffered).

## Test plan
- Reset, then push `op`=000 a=3 b=5 with `out_ready`=1 → `out_valid` 3 cycles later, `out_result`=8, `out_op`=000, single-cycle valid.
- Push 15+1, 1−2, 1100&1010, 1100|1010, not 0101 back-to-back → results 0, 15, 1000, 1110, 1010 in order, spaced 3 cycles, no loss or duplication.
- Push `op`=101 → `err` pulses one cycle, `count` unchanged, no `out_valid`. Then push a legal command → processed normally.
- Hold `out_ready`=0 and push 6 commands → 5 accepted, `in_ready`=0 with `count`=4. Release `out_ready` → 5 results in order, then `in_ready` reasserts.
- Assert `rst` one cycle while in EXEC with `count`=2 → next cycle all outputs at reset values, `count`=0. No stale result appears afterwards.
- Drive `out_ready` low for 3 cycles during HOLD → `out_result`/`out_op` stable. The handshake edge with `count`>0 reissues immediately.
